// File: rtl/adder_subtractor_8b_if.sv
// Operand/result bundle for the registered 8-bit adder-subtractor.
// ADDSUB_OVERFLOW_EN adds the signed-overflow flag Ovf.
interface adder_subtractor_8b_if;
    logic       enable;
    logic [7:0] A;
    logic [7:0] B;
    logic       Ctl;
    logic [7:0] Sum;
    logic [7:0] Difference;
    logic       Cout;
`ifdef ADDSUB_OVERFLOW_EN
    logic       Ovf;
`endif

    modport master (
        output enable, A, B, Ctl,
`ifdef ADDSUB_OVERFLOW_EN
        input  Ovf,
`endif
        input  Sum, Difference, Cout
    );

    modport slave (
        input  enable, A, B, Ctl,
`ifdef ADDSUB_OVERFLOW_EN
        output Ovf,
`endif
        output Sum, Difference, Cout
    );
endinterface

// File: rtl/adder_subtractor_8b.sv
// Registered 8-bit ripple-carry adder-subtractor (Ctl=1 subtracts).
// ADDSUB_OVERFLOW_EN adds a registered two's-complement overflow flag.
module adder_subtractor_8b (
    input  logic                 clk,
    input  logic                 rst,
    adder_subtractor_8b_if.slave bus
);
    logic [7:0] bx;
    logic [7:0] r;
    logic       carry;
    logic       cout;
`ifdef ADDSUB_OVERFLOW_EN
    logic       c7;
    logic       ovf_q;
`endif
    logic [7:0] sum_q;
    logic [7:0] diff_q;
    logic       cout_q;

    // Subtract reuses the adder: invert B and inject Ctl as carry-in.
    always_comb begin
        bx    = bus.B ^ {8{bus.Ctl}};
        r     = '0;
        carry = bus.Ctl;
`ifdef ADDSUB_OVERFLOW_EN
        c7    = 1'b0;
`endif
        for (int i = 0; i < 8; i++) begin
`ifdef ADDSUB_OVERFLOW_EN
            if (i == 7) c7 = carry;
`endif
            r[i]  = bus.A[i] ^ bx[i] ^ carry;
            carry = (bus.A[i] & bx[i]) | (carry & (bus.A[i] ^ bx[i]));
        end
        cout = carry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            diff_q <= '0;
            cout_q <= 1'b0;
`ifdef ADDSUB_OVERFLOW_EN
            ovf_q  <= 1'b0;
`endif
        end else if (bus.enable) begin
            sum_q  <= bus.Ctl ? 8'h00 : r;
            diff_q <= bus.Ctl ? r : 8'h00;
            cout_q <= cout;
`ifdef ADDSUB_OVERFLOW_EN
            ovf_q  <= c7 ^ cout;
`endif
        end
    end

    assign bus.Sum        = sum_q;
    assign bus.Difference = diff_q;
    assign bus.Cout       = cout_q;
`ifdef ADDSUB_OVERFLOW_EN
    assign bus.Ovf        = ovf_q;
`endif
endmodule

// File: tb/tb_adder_subtractor_8b.sv
// Directed-vector bench for adder_subtractor_8b.
// Overflow checks build only with ADDSUB_OVERFLOW_EN.
module tb_adder_subtractor_8b;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    adder_subtractor_8b_if ifc ();

    adder_subtractor_8b dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [7:0] a,
                         input logic [7:0] b, input logic ctl);
        ifc.enable = en;
        ifc.A      = a;
        ifc.B      = b;
        ifc.Ctl    = ctl;
    endtask

    task automatic chk_all(input string tag, input logic [7:0] s,
                           input logic [7:0] d, input logic c);
        chk({tag, ".sum"},  ifc.Sum, s);
        chk({tag, ".diff"}, ifc.Difference, d);
        chk({tag, ".cout"}, {7'd0, ifc.Cout}, {7'd0, c});
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 8'd0, 8'd0, 1'b0);
        step();
        step();
        rst = 1'b0;
        chk_all("reset", 8'h00, 8'h00, 1'b0);
`ifdef ADDSUB_OVERFLOW_EN
        chk("reset.ovf", {7'd0, ifc.Ovf}, 8'd0);
`endif

        drive(1'b0, 8'd28, 8'd34, 1'b0);
        step(); step(); step();
        chk_all("idle", 8'h00, 8'h00, 1'b0);

        drive(1'b1, 8'd28, 8'd34, 1'b0);
        step();
        chk_all("add28_34", 8'h3E, 8'h00, 1'b0);
        drive(1'b1, 8'd255, 8'd34, 1'b0);
        step();
        chk_all("add255_34", 8'h21, 8'h00, 1'b1);

        drive(1'b1, 8'd28, 8'd34, 1'b1);
        step();
        chk_all("sub28_34", 8'h00, 8'hFA, 1'b0);
        drive(1'b1, 8'd0, 8'd1, 1'b1);
        step();
        chk_all("sub0_1", 8'h00, 8'hFF, 1'b0);
        drive(1'b1, 8'd1, 8'd0, 1'b1);
        step();
        chk_all("sub1_0", 8'h00, 8'h01, 1'b1);
        drive(1'b1, 8'd22, 8'd22, 1'b1);
        step();
        chk_all("sub22_22", 8'h00, 8'h00, 1'b1);
        drive(1'b1, 8'd255, 8'd34, 1'b1);
        step();
        chk_all("sub255_34", 8'h00, 8'hDD, 1'b1);
`ifdef ADDSUB_OVERFLOW_EN
        chk("sub255_34.ovf", {7'd0, ifc.Ovf}, 8'd0);
`endif

        drive(1'b0, 8'd7, 8'd200, 1'b0);
        step(); step();
        chk_all("hold", 8'h00, 8'hDD, 1'b1);

        drive(1'b1, 8'd1, 8'd1, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_all("rst_pri", 8'h00, 8'h00, 1'b0);
        step();
        chk_all("post_rst", 8'h02, 8'h00, 1'b0);

`ifdef ADDSUB_OVERFLOW_EN
        drive(1'b1, 8'd100, 8'd100, 1'b0);
        step();
        chk("ovf_add.sum", ifc.Sum, 8'hC8);
        chk("ovf_add.ovf", {7'd0, ifc.Ovf}, 8'd1);
        drive(1'b1, 8'h80, 8'h01, 1'b1);
        step();
        chk("ovf_sub.diff", ifc.Difference, 8'h7F);
        chk("ovf_sub.ovf", {7'd0, ifc.Ovf}, 8'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
